// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/IR/memory side.
// The master side is the FSM: it consumes IR fields and status, and drives the enables.
interface mc_control_fsm_if;
    logic       run;
    logic [3:0] opcode;
    logic [3:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       md_done;
    logic [1:0] ALUop;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       mem_to_reg;
    logic       md_start;
    logic       halted;
    logic       fault;
    logic [3:0] state_out;

    modport master (
        input  run, opcode, funct, zero, mem_ready, md_done,
        output ALUop, pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               alu_src_b, reg_write, mem_to_reg, md_start, halted, fault, state_out
    );

    modport slave (
        output run, opcode, funct, zero, mem_ready, md_done,
        input  ALUop, pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               alu_src_b, reg_write, mem_to_reg, md_start, halted, fault, state_out
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 16-bit processor: fetch/decode/execute/memory/writeback
// sequencing with memory-ready and mult/div start/done stalls, plus a sticky fault halt.
module mc_control_fsm #(
    parameter int unsigned MD_TIMEOUT = 32,
    parameter int unsigned CNT_W      = 6
) (
    input logic             clk,
    input logic             reset,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WAIT_MD  = 4'd4,
        WB_R     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_LD    = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        HALT     = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fault_d       = fault_q;
        bus.ALUop     = 2'b00;
        bus.pc_write  = 1'b0;
        bus.pc_src    = 2'b00;
        bus.ir_write  = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.iord      = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.reg_write = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.md_start  = 1'b0;
        bus.halted    = 1'b0;

        case (state_q)
            IDLE: if (bus.run) state_d = FETCH;
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ALUop     = 2'b10;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                bus.ALUop     = 2'b10;
                bus.alu_src_b = 2'b10;
                case (bus.opcode)
                    4'b1111:          state_d = EXEC_R;
                    4'b1000, 4'b1011: state_d = MEM_ADDR;
                    4'b0100:          state_d = BRANCH;
                    4'b1100:          state_d = JUMP;
                    4'b0000:          state_d = HALT;
                    default: begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end
            EXEC_R: begin
                bus.ALUop = 2'b11;
                if (bus.funct == 4'b0100 || bus.funct == 4'b0101) begin
                    bus.md_start = 1'b1;
                    cnt_d        = '0;
                    state_d      = WAIT_MD;
                end else begin
                    state_d = WB_R;
                end
            end
            WAIT_MD: begin
                bus.ALUop = 2'b11;
                cnt_d     = cnt_q + CNT_W'(1);
                // md_done takes priority over a timeout landing in the same cycle
                if (bus.md_done) begin
                    state_d = WB_R;
                end else if (cnt_d == CNT_W'(MD_TIMEOUT)) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end
            end
            WB_R: begin
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            MEM_ADDR: begin
                bus.ALUop     = 2'b10;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == 4'b1011) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = WB_LD;
            end
            WB_LD: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            BRANCH: begin
                bus.ALUop    = 2'b01;
                bus.pc_src   = 2'b01;
                bus.pc_write = bus.zero;
                state_d      = FETCH;
            end
            JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
                state_d      = FETCH;
            end
            HALT:    bus.halted = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    assign bus.state_out = state_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instructions expand into expected per-cycle state traces,
// and every cycle the DUT outputs are compared with the output table for that state.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm #(.MD_TIMEOUT(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         st;
        logic       run;
        logic [3:0] opc;
        logic [3:0] fn;
        logic       z;
        logic       mr;
        logic       mdd;
        logic       fault;
    } rec_t;

    rec_t q[$];
    logic m_fault;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cnt_state[13];
    int   cnt_mds;
    int   cnt_brw;

    logic [14:0] dut_out;
    assign dut_out = {bus.ALUop, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read,
                      bus.mem_write, bus.iord, bus.alu_src_b, bus.reg_write,
                      bus.mem_to_reg, bus.md_start, bus.halted};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(int st, logic run, logic [3:0] opc, logic [3:0] fn,
                                 logic z, logic mr, logic mdd);
        rec_t r;
        r.st = st; r.run = run; r.opc = opc; r.fn = fn;
        r.z = z; r.mr = mr; r.mdd = mdd; r.fault = m_fault;
        q.push_back(r);
    endfunction

    // Expected outputs for one cycle, straight from the per-state output rules.
    function automatic logic [14:0] exp_out(rec_t r);
        logic [1:0] aluop, pcsrc, srcb;
        logic pcw, irw, mrd, mwr, iord, rw, m2r, mds, hlt;
        aluop = 2'b00; pcsrc = 2'b00; srcb = 2'b00;
        pcw = 0; irw = 0; mrd = 0; mwr = 0; iord = 0; rw = 0; m2r = 0; mds = 0; hlt = 0;
        case (r.st)
            1:  begin mrd = 1; srcb = 2'b01; aluop = 2'b10; irw = r.mr; pcw = r.mr; end
            2:  begin aluop = 2'b10; srcb = 2'b10; end
            3:  begin aluop = 2'b11; mds = (r.fn == 4'd4 || r.fn == 4'd5); end
            4:  aluop = 2'b11;
            5:  rw = 1;
            6:  begin aluop = 2'b10; srcb = 2'b10; end
            7:  begin mrd = 1; iord = 1; end
            8:  begin rw = 1; m2r = 1; end
            9:  begin mwr = 1; iord = 1; end
            10: begin aluop = 2'b01; pcsrc = 2'b01; pcw = r.z; end
            11: begin pcsrc = 2'b10; pcw = 1; end
            12: hlt = 1;
            default: ;
        endcase
        return {aluop, pcw, pcsrc, irw, mrd, mwr, iord, srcb, rw, m2r, mds, hlt};
    endfunction

    // Expand one instruction into its expected cycle-by-cycle trace and stimulus.
    // md_lat = cycles from md_start to md_done; 0 means md_done never comes.
    task automatic add_instr(input logic [3:0] opc, input logic [3:0] fn, input int fw,
                             input int mw, input int md_lat, input logic z);
        for (int i = 0; i < fw; i++) push(1, 0, opc, fn, 0, 0, 0);
        push(1, 0, opc, fn, 0, 1, 0);
        push(2, 0, opc, fn, 0, 0, 0);
        case (opc)
            4'hF: begin
                push(3, 0, opc, fn, 0, 0, 0);
                if (fn == 4'd4 || fn == 4'd5) begin
                    if (md_lat > 0) begin
                        for (int i = 1; i < md_lat; i++) push(4, 0, opc, fn, 0, 0, 0);
                        push(4, 0, opc, fn, 0, 0, 1);
                        push(5, 0, opc, fn, 0, 0, 0);
                    end else begin
                        for (int i = 0; i < 32; i++) push(4, 0, opc, fn, 0, 0, 0);
                        m_fault = 1'b1;
                        push(12, 0, opc, fn, 0, 0, 0);
                    end
                end else begin
                    push(5, 0, opc, fn, 0, 0, 0);
                end
            end
            4'h8: begin
                push(6, 0, opc, fn, 0, 0, 0);
                for (int i = 0; i < mw; i++) push(7, 0, opc, fn, 0, 0, 0);
                push(7, 0, opc, fn, 0, 1, 0);
                push(8, 0, opc, fn, 0, 0, 0);
            end
            4'hB: begin
                push(6, 0, opc, fn, 0, 0, 0);
                for (int i = 0; i < mw; i++) push(9, 0, opc, fn, 0, 0, 0);
                push(9, 0, opc, fn, 0, 1, 0);
            end
            4'h4: push(10, 0, opc, fn, z, 0, 0);
            4'hC: push(11, 0, opc, fn, 0, 0, 0);
            4'h0: push(12, 0, opc, fn, 0, 0, 0);
            default: begin
                m_fault = 1'b1;
                push(12, 0, opc, fn, 0, 0, 0);
            end
        endcase
    endtask

    task automatic clear_tally();
        foreach (cnt_state[i]) cnt_state[i] = 0;
        cnt_mds = 0;
        cnt_brw = 0;
    endtask

    task automatic run_queue();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            bus.run = r.run; bus.opcode = r.opc; bus.funct = r.fn;
            bus.zero = r.z; bus.mem_ready = r.mr; bus.md_done = r.mdd;
            #1;
            check("outputs", 32'(dut_out), 32'(exp_out(r)));
            check("state_out", 32'(bus.state_out), 32'(r.st));
            check("fault", 32'(bus.fault), 32'(r.fault));
            if (bus.state_out <= 4'd12) cnt_state[bus.state_out]++;
            if (bus.md_start) cnt_mds++;
            if (bus.state_out == 4'd10 && bus.pc_write) cnt_brw++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.run = 0; bus.opcode = 0; bus.funct = 0;
        bus.zero = 0; bus.mem_ready = 0; bus.md_done = 0;
        #1;
        check("reset_outputs", 32'(dut_out), 32'd0);
        check("reset_state", 32'(bus.state_out), 32'd0);
        check("reset_fault", 32'(bus.fault), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_fault = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_fault = 1'b0;
        do_reset();

        // R-type add with no memory wait: exactly four cycles
        clear_tally();
        push(0, 1, 4'hF, 4'h0, 0, 0, 0);
        add_instr(4'hF, 4'h0, 0, 0, 0, 0);
        run_queue();
        check("radd_cycles", 32'(cnt_state[1] + cnt_state[2] + cnt_state[3] + cnt_state[5]), 32'd4);
        check("radd_wb", 32'(cnt_state[5]), 32'd1);

        // fetch stall then multiply with md_done 5 cycles after md_start
        clear_tally();
        add_instr(4'hF, 4'h4, 2, 0, 5, 0);
        run_queue();
        check("mul_start_pulses", 32'(cnt_mds), 32'd1);
        check("mul_wait_cycles", 32'(cnt_state[4]), 32'd5);
        check("mul_fetch_cycles", 32'(cnt_state[1]), 32'd3);

        clear_tally();
        add_instr(4'h8, 4'h0, 0, 3, 0, 0);
        run_queue();
        check("load_memrd_cycles", 32'(cnt_state[7]), 32'd4);
        check("load_wbld_cycles", 32'(cnt_state[8]), 32'd1);

        add_instr(4'hB, 4'h0, 0, 1, 0, 0);
        add_instr(4'hC, 4'h0, 0, 0, 0, 0);
        run_queue();

        clear_tally();
        add_instr(4'h4, 4'h0, 0, 0, 0, 1);
        run_queue();
        check("beq_taken_pcwrite", 32'(cnt_brw), 32'd1);
        clear_tally();
        add_instr(4'h4, 4'h0, 0, 0, 0, 0);
        run_queue();
        check("beq_not_taken_pcwrite", 32'(cnt_brw), 32'd0);

        // divide that never completes: timeout halt, run ignored afterwards
        clear_tally();
        add_instr(4'hF, 4'h5, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) push(12, 1, 4'hF, 4'h5, 0, 1, 1);
        run_queue();
        check("div_wait_cycles", 32'(cnt_state[4]), 32'd32);
        check("div_fault", 32'(bus.fault), 32'd1);
        check("div_halted", 32'(bus.halted), 32'd1);

        // illegal opcode
        do_reset();
        push(0, 1, 4'h3, 4'h0, 0, 0, 0);
        add_instr(4'h3, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(12, 1, 4'h3, 4'h0, 0, 1, 0);
        run_queue();
        check("illegal_fault", 32'(bus.fault), 32'd1);
        check("illegal_state", 32'(bus.state_out), 32'd12);

        // legal halt opcode: no fault
        do_reset();
        push(0, 1, 4'h0, 4'h0, 0, 0, 0);
        add_instr(4'h0, 4'h0, 0, 0, 0, 0);
        push(12, 1, 4'h0, 4'h0, 0, 0, 0);
        run_queue();
        check("halt_no_fault", 32'(bus.fault), 32'd0);

        // reset in the middle of a stalled store
        do_reset();
        push(0, 1, 4'hB, 4'h0, 0, 0, 0);
        add_instr(4'hB, 4'h0, 0, 3, 0, 0);
        void'(q.pop_back());
        run_queue();
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("store_mem_write_before_reset", 32'(bus.mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("store_mem_write_after_reset", 32'(bus.mem_write), 32'd0);
        check("store_state_after_reset", 32'(bus.state_out), 32'd0);
        check("store_outputs_after_reset", 32'(dut_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
